ahblite_decoder_mux: RTL and testbench
======================================

Name: ahblite_decoder_mux

Overview:
- Parametrised next-generation AHB-Lite address decoder plus data-phase response multiplexer.
- Sits between the single AHB-Lite master (core) and up to 8 slave ports, e.g. RAMCODE, RAMDATA, APB bridge, accelerators.
- Decodes HADDR[31:16] against per-port base/mask in the address phase and registers the selected port for the data phase.
- Steers HREADYOUT/HRDATA/HRESP from that port back to the master.
- Includes a built-in default slave that returns a two-cycle AHB ERROR for unmapped NONSEQ/SEQ transfers.

Parameters:
- NUM_PORTS, 4, number of slave ports; legal 1..8.
- PORT_EN, 8'hFF, per-port enable bitmask; bit i=0 forces port i never selected.
- PORT_BASE, {8{16'h0000}}, packed NUM_PORTS*16 vector; port i base compared against HADDR[31:16].
- PORT_MASK, {8{16'hFFFF}}, packed NUM_PORTS*16 vector; port i hits when (HADDR[31:16] & mask) == (base & mask).

Ports:
- HCLK  input  1  system clock, all state on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  1  global select for this decoder.
- HADDR  input  32  master address.
- HTRANS  input  2  master transfer type.
- HREADY  input  1  bus-wide ready (fed back from HREADYOUT by the interconnect).
- P_HSEL  output  NUM_PORTS  one-hot address-phase slave selects (combinational).
- P_HREADYOUT  input  NUM_PORTS  per-slave ready.
- P_HRDATA  input  NUM_PORTS*32  per-slave read data, port i at [32i+31:32i].
- P_HRESP  input  NUM_PORTS  per-slave response.
- HREADYOUT  output  1  muxed ready to master.
- HRDATA  output  32  muxed read data.
- HRESP  output  1  muxed response.
- DEC_ERR  output  1  one-cycle pulse when an unmapped active transfer is accepted.

Behaviour:
- Hit vector:
  - hit[i] = PORT_EN[i] & HSEL & ((HADDR[31:16] & PORT_MASK[i]) == (PORT_BASE[i] & PORT_MASK[i])).
  - Overlapping hits resolve to the lowest index, so P_HSEL is always one-hot or zero.
- P_HSEL is purely combinational and independent of HTRANS. Slaves qualify it with HTRANS and HREADY themselves.
- Miss: HSEL=1, HTRANS[1]=1 and no hit selects the default slave.
- Data-phase select register sel_q:
  - Width NUM_PORTS+1, one-hot; bit NUM_PORTS is the default slave.
  - Loaded on each rising edge with HREADY=1.
  - Holds while HREADY=0.
  - Loads all-zero when HSEL=0, or when HTRANS is IDLE/BUSY and there is no hit.
- Output mux:
  - sel_q port i: outputs follow P_HREADYOUT[i], P_HRDATA[i], P_HRESP[i].
  - sel_q all-zero: HREADYOUT=1, HRESP=0, HRDATA=0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADYOUT=1, HRESP=0. Go to ERR1 when HREADY=1 and the miss condition holds.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2 next cycle.
  - ERR2: HREADYOUT=1, HRESP=1. Go to ERR1 if a new miss is accepted this cycle (HREADY=1 here), else IDLE.
- DEC_ERR: registered; high for exactly the cycle the FSM is in ERR1.
- Reset (HRESET=1 at an edge), including mid-transfer: sel_q=0, FSM=IDLE, DEC_ERR=0. Next cycle HREADYOUT=1, HRESP=0, HRDATA=0. Any in-flight data phase is abandoned.
- Data-phase latency: 0 cycles added; responses pass combinationally from slave to master.
- Back-to-back transfers to different ports switch the mux exactly on the HREADY=1 edge.

Optional Feature:
- Macro: DECODER_ERR_COUNT_EN.
- Defined:
  - Adds output ERR_COUNT [15:0] and input ERR_CLR [0:0].
  - ERR_COUNT increments on each DEC_ERR pulse and saturates at 16'hFFFF.
  - ERR_CLR=1 clears it to 0 on the next edge; clear wins over a simultaneous increment.
  - HRESET clears it to 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Decode/mux: NUM_PORTS=3, bases 0000/2000/4000, mask FFFF, NONSEQ read 0x2000_0010 with P_HRDATA[1]=32'hDEADBEEF -> P_HSEL=3'b010 in address phase; HRDATA=DEADBEEF, HRESP=0 next cycle.
- Wait states: port 0 holds P_HREADYOUT=0 for 3 cycles during a read while HADDR moves to 0x4000_0000 -> sel_q stays port 0; HREADYOUT low 3 cycles; switches to port 2 only after the HREADY=1 edge.
- Unmapped: NONSEQ to 0x3000_0000 -> HREADYOUT=0,HRESP=1 then HREADYOUT=1,HRESP=1, then IDLE; DEC_ERR pulses once; P_HSEL=0.
- Back-to-back misses: two consecutive NONSEQ to 0x5000_0000 -> sequence ERR1,ERR2,ERR1,ERR2,IDLE; DEC_ERR pulses twice.
- Overlap and enable: mask 16'hF000 on port 0 base 0x0000 and port 1 base 0x0000 -> only port 0 selected; with PORT_EN=8'hFE the same access goes to port 1.
- Reset mid-ERR1 and counter: HRESET asserted during ERR1 -> next cycle HREADYOUT=1, HRESP=0. With DECODER_ERR_COUNT_EN, 3 misses -> ERR_COUNT=3; ERR_CLR coincident with a 4th miss -> ERR_COUNT=0.

Source files
------------

// File: rtl/ahblite_decoder_mux_if.sv
// ahblite_decoder_mux_if: AHB-Lite decoder/mux bus bundle
// slave modport is the decoder's view, master modport is the driving side.
// ERR_COUNT/ERR_CLR exist only when DECODER_ERR_COUNT_EN is defined.
interface ahblite_decoder_mux_if #(parameter int NUM_PORTS = 4);
  logic                   HSEL;
  logic [31:0]            HADDR;
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [NUM_PORTS-1:0]   P_HSEL;
  logic [NUM_PORTS-1:0]   P_HREADYOUT;
  logic [NUM_PORTS*32-1:0] P_HRDATA;
  logic [NUM_PORTS-1:0]   P_HRESP;
  logic                   HREADYOUT;
  logic [31:0]            HRDATA;
  logic                   HRESP;
  logic                   DEC_ERR;
`ifdef DECODER_ERR_COUNT_EN
  logic [15:0]            ERR_COUNT;
  logic                   ERR_CLR;
`endif
  modport slave(
    input HSEL, HADDR, HTRANS, HREADY, P_HREADYOUT, P_HRDATA, P_HRESP,
`ifdef DECODER_ERR_COUNT_EN
    input ERR_CLR, output ERR_COUNT,
`endif
    output P_HSEL, HREADYOUT, HRDATA, HRESP, DEC_ERR
  );
  modport master(
    output HSEL, HADDR, HTRANS, HREADY, P_HREADYOUT, P_HRDATA, P_HRESP,
`ifdef DECODER_ERR_COUNT_EN
    output ERR_CLR, input ERR_COUNT,
`endif
    input P_HSEL, HREADYOUT, HRDATA, HRESP, DEC_ERR
  );
endinterface

// File: rtl/ahblite_decoder_mux.sv
// ahblite_decoder_mux: AHB-Lite address decoder, response mux and default error slave
// Ports: HCLK, HRESET (sync, active-high), bus (ahblite_decoder_mux_if.slave):
//   address phase HSEL/HADDR/HTRANS/HREADY -> one-hot P_HSEL;
//   data phase P_HREADYOUT/P_HRDATA/P_HRESP -> HREADYOUT/HRDATA/HRESP; DEC_ERR pulse.
// Optional macro DECODER_ERR_COUNT_EN adds ERR_COUNT (saturating) and ERR_CLR.
module ahblite_decoder_mux #(
  parameter int                     NUM_PORTS = 4,
  parameter logic [7:0]             PORT_EN   = 8'hFF,
  parameter logic [NUM_PORTS*16-1:0] PORT_BASE = '0,
  parameter logic [NUM_PORTS*16-1:0] PORT_MASK = '1
) (
  input logic HCLK,
  input logic HRESET,
  ahblite_decoder_mux_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t               state, state_nxt;
  logic [NUM_PORTS-1:0] hit, p_sel;
  logic [NUM_PORTS:0]   sel_q;
  logic                 miss, err_ready, err_resp, dec_err, ready, resp;
  logic [31:0]          rdata;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_hit
    assign hit[i] = PORT_EN[i] & bus.HSEL &
      ((bus.HADDR[31:16] & PORT_MASK[16*i +: 16]) == (PORT_BASE[16*i +: 16] & PORT_MASK[16*i +: 16]));
  end
  // isolate the lowest set bit so overlapping windows resolve to the lowest port
  assign p_sel = hit & (~hit + NUM_PORTS'(1));
  assign miss = bus.HSEL & bus.HTRANS[1] & ~|hit;
  assign state_nxt = (state == ERR1) ? ERR2 : (bus.HREADY && miss) ? ERR1 : IDLE;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q     <= '0;
      state     <= IDLE;
      err_ready <= 1'b1;
      err_resp  <= 1'b0;
      dec_err   <= 1'b0;
    end else begin
      if (bus.HREADY) sel_q <= {miss, p_sel};
      state     <= state_nxt;
      err_ready <= state_nxt != ERR1;
      err_resp  <= state_nxt != IDLE;
      dec_err   <= state_nxt == ERR1;
    end
  end
  always_comb begin
    ready = 1'b1;
    resp  = 1'b0;
    rdata = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (sel_q[j]) begin
        ready = bus.P_HREADYOUT[j];
        resp  = bus.P_HRESP[j];
        rdata = bus.P_HRDATA[32*j +: 32];
      end
    end
    if (sel_q[NUM_PORTS]) begin
      ready = err_ready;
      resp  = err_resp;
    end
  end
  assign bus.P_HSEL    = p_sel;
  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    = rdata;
  assign bus.DEC_ERR   = dec_err;
`ifdef DECODER_ERR_COUNT_EN
  logic [15:0] err_count;
  always_ff @(posedge HCLK)
    err_count <= (HRESET || bus.ERR_CLR) ? '0 :
                 (dec_err && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
  assign bus.ERR_COUNT = err_count;
`endif
endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// tb_ahblite_decoder_mux: directed bench with a transaction-level reference model
module tb_ahblite_decoder_mux;
  localparam int N = 3;
  localparam logic [15:0] BASE [N] = '{16'h0000, 16'h2000, 16'h4000};
  localparam logic [31:0] PDATA[N] = '{32'h1111_0000, 32'hDEADBEEF, 32'h2222_2222};
  localparam logic        PRESP[N] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, mvalid = 1'b0;
  logic [2:0] p_rdy = 3'b111;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  ahblite_decoder_mux_if #(.NUM_PORTS(3)) ia();
  ahblite_decoder_mux_if #(.NUM_PORTS(2)) ib();
  ahblite_decoder_mux_if #(.NUM_PORTS(2)) ic();

  ahblite_decoder_mux #(.NUM_PORTS(3), .PORT_EN(8'hFF),
    .PORT_BASE({16'h4000, 16'h2000, 16'h0000}), .PORT_MASK({3{16'hFFFF}}))
    dut_a (.HCLK(clk), .HRESET(rst), .bus(ia.slave));
  ahblite_decoder_mux #(.NUM_PORTS(2), .PORT_EN(8'hFF),
    .PORT_BASE(32'h0), .PORT_MASK({2{16'hF000}}))
    dut_b (.HCLK(clk), .HRESET(rst), .bus(ib.slave));
  ahblite_decoder_mux #(.NUM_PORTS(2), .PORT_EN(8'hFE),
    .PORT_BASE(32'h0), .PORT_MASK({2{16'hF000}}))
    dut_c (.HCLK(clk), .HRESET(rst), .bus(ic.slave));

  assign ia.P_HREADYOUT = p_rdy;
  assign ia.P_HRDATA    = {PDATA[2], PDATA[1], PDATA[0]};
  assign ia.P_HRESP     = {PRESP[2], PRESP[1], PRESP[0]};
  assign ib.HSEL = ia.HSEL;   assign ic.HSEL = ia.HSEL;
  assign ib.HADDR = ia.HADDR; assign ic.HADDR = ia.HADDR;
  assign ib.HTRANS = ia.HTRANS; assign ic.HTRANS = ia.HTRANS;
  assign ib.HREADY = 1'b1;    assign ic.HREADY = 1'b1;
  assign ib.P_HREADYOUT = '1; assign ic.P_HREADYOUT = '1;
  assign ib.P_HRDATA = '0;    assign ic.P_HRDATA = '0;
  assign ib.P_HRESP = '0;     assign ic.P_HRESP = '0;
`ifdef DECODER_ERR_COUNT_EN
  assign ia.ERR_CLR = clr; assign ib.ERR_CLR = 1'b0; assign ic.ERR_CLR = 1'b0;
`endif

  // reference model: tgt is the data-phase owner (-1 none, N = error slave),
  // ecyc counts cycles into the two-cycle error response
  function automatic int first_hit(input logic s, input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (s && ((a[31:16] ^ BASE[i]) == 16'h0)) return i;
    return -1;
  endfunction
  function automatic int target(input logic s, input logic [31:0] a, input logic [1:0] t);
    int h;
    h = first_hit(s, a);
    if (h >= 0) return h;
    return (s && t[1]) ? N : -1;
  endfunction

  int tgt = -1, ecyc = 0, nt;
  logic [15:0] exp_cnt = '0;
  logic [2:0]  exp_psel;
  logic        exp_rdy, exp_resp, exp_dec;
  logic [31:0] exp_data;
  int fh;
  always_comb begin
    fh = first_hit(ia.HSEL, ia.HADDR);
    exp_psel = (fh < 0) ? 3'b000 : 3'(1 << fh);
    exp_rdy = 1'b1; exp_resp = 1'b0; exp_data = '0;
    if (tgt == N) begin
      exp_rdy = (ecyc != 1); exp_resp = 1'b1;
    end else if (tgt >= 0) begin
      exp_rdy = p_rdy[tgt]; exp_resp = PRESP[tgt]; exp_data = PDATA[tgt];
    end
    exp_dec = (tgt == N) && (ecyc == 1);
  end
  assign ia.HREADY = exp_rdy;

  always @(posedge clk) begin
    if (rst) begin
      tgt <= -1; ecyc <= 0; mvalid <= 1'b1;
    end else if (exp_rdy) begin
      nt = target(ia.HSEL, ia.HADDR, ia.HTRANS);
      tgt <= nt; ecyc <= (nt == N) ? 1 : 0;
    end else if (tgt == N) ecyc <= 2;
    exp_cnt <= (rst || clr) ? 16'h0 : (exp_dec && exp_cnt != 16'hFFFF) ? exp_cnt + 16'd1 : exp_cnt;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (mvalid) begin
    chk("model_p_hsel", 32'(ia.P_HSEL), 32'(exp_psel));
    chk("model_hreadyout", 32'(ia.HREADYOUT), 32'(exp_rdy));
    chk("model_hresp", 32'(ia.HRESP), 32'(exp_resp));
    chk("model_hrdata", ia.HRDATA, exp_data);
    chk("model_dec_err", 32'(ia.DEC_ERR), 32'(exp_dec));
`ifdef DECODER_ERR_COUNT_EN
    chk("model_err_count", 32'(ia.ERR_COUNT), 32'(exp_cnt));
`endif
  end

  task automatic drive(input logic r, input logic s, input logic [31:0] a,
                       input logic [1:0] t, input logic [2:0] rdy);
    @(posedge clk); #1;
    rst = r; ia.HSEL = s; ia.HADDR = a; ia.HTRANS = t; p_rdy = rdy;
    @(negedge clk);
  endtask

  initial begin
    ia.HSEL = 1'b0; ia.HADDR = '0; ia.HTRANS = 2'b00;
    drive(1, 0, 0, 0, 3'b111);
    drive(1, 0, 0, 0, 3'b111);
    drive(0, 0, 0, 0, 3'b111);
    chk("rst_hreadyout", 32'(ia.HREADYOUT), 1);
    chk("rst_hresp", 32'(ia.HRESP), 0);
    chk("rst_hrdata", ia.HRDATA, 0);
    chk("rst_dec_err", 32'(ia.DEC_ERR), 0);
    // decode and mux
    drive(0, 1, 32'h2000_0010, 2'b10, 3'b111);
    chk("dec_p_hsel", 32'(ia.P_HSEL), 32'b010);
    drive(0, 0, 0, 0, 3'b111);
    chk("dec_hrdata", ia.HRDATA, 32'hDEADBEEF);
    chk("dec_hresp", 32'(ia.HRESP), 0);
    // wait states on port 0 while the next address targets port 2
    drive(0, 1, 32'h0000_0040, 2'b10, 3'b111);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h4000_0000, 2'b10, 3'b110);
      chk("wait_hreadyout", 32'(ia.HREADYOUT), 0);
    end
    drive(0, 1, 32'h4000_0000, 2'b10, 3'b111);
    chk("wait_release_hrdata", ia.HRDATA, 32'h1111_0000);
    drive(0, 0, 0, 0, 3'b111);
    chk("switch_hrdata", ia.HRDATA, 32'h2222_2222);
    chk("switch_hresp", 32'(ia.HRESP), 1);
    // unmapped access
    drive(0, 1, 32'h3000_0000, 2'b10, 3'b111);
    chk("miss_p_hsel", 32'(ia.P_HSEL), 0);
    drive(0, 0, 0, 0, 3'b111);
    chk("miss_err1", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b011);
    drive(0, 0, 0, 0, 3'b111);
    chk("miss_err2", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b110);
    drive(0, 0, 0, 0, 3'b111);
    chk("miss_idle", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b100);
    // back-to-back misses
    drive(0, 1, 32'h5000_0000, 2'b10, 3'b111);
    drive(0, 1, 32'h5000_0000, 2'b10, 3'b111);
    chk("b2b_err1a", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b011);
    drive(0, 1, 32'h5000_0000, 2'b10, 3'b111);
    chk("b2b_err2a", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b110);
    drive(0, 0, 0, 0, 3'b111);
    chk("b2b_err1b", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b011);
    drive(0, 0, 0, 0, 3'b111);
    chk("b2b_err2b", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b110);
    drive(0, 0, 0, 0, 3'b111);
    chk("b2b_idle", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b100);
`ifdef DECODER_ERR_COUNT_EN
    chk("cnt_three", 32'(ia.ERR_COUNT), 3);
    drive(0, 1, 32'h3000_0000, 2'b10, 3'b111);
    drive(0, 0, 0, 0, 3'b111);
    clr = 1'b1;
    drive(0, 0, 0, 0, 3'b111);
    chk("cnt_clr_wins", 32'(ia.ERR_COUNT), 0);
    clr = 1'b0;
    drive(0, 0, 0, 0, 3'b111);
`endif
    // overlapping windows and port enable
    drive(0, 1, 32'h0000_1234, 2'b00, 3'b111);
    chk("ovl_b_p_hsel", 32'(ib.P_HSEL), 32'b01);
    chk("ovl_c_p_hsel", 32'(ic.P_HSEL), 32'b10);
    drive(0, 1, 32'h1000_0000, 2'b00, 3'b111);
    chk("ovl_b_none", 32'(ib.P_HSEL), 0);
    chk("ovl_c_none", 32'(ic.P_HSEL), 0);
    // reset during ERR1
    drive(0, 1, 32'h3000_0000, 2'b10, 3'b111);
    drive(1, 0, 0, 0, 3'b111);
    chk("rstmid_err1", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b011);
    drive(0, 0, 0, 0, 3'b111);
    chk("rstmid_after", {ia.HREADYOUT, ia.HRESP, ia.DEC_ERR}, 3'b100);
    chk("rstmid_hrdata", ia.HRDATA, 0);
    drive(0, 0, 0, 0, 3'b111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
